// File: rtl/dunc_core.sv
// dunc_core: parametrised accumulator CPU core with a Moore FSM and a req/ack memory handshake.
module dunc_core #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_ACK,
  output logic [AW-1:0] PC_OUT,
  output logic [DW-1:0] AC_OUT,
  output logic [3:0]    IR_OUT,
  output logic          AZ,
  output logic          AN,
  output logic          FETCH,
  output logic          HALTED
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'h0, OP_STA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_AND = 4'h4, OP_JMP = 4'h5, OP_BAN = 4'h6, OP_BAZ = 4'h7, OP_HLT = 4'hF;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, op_q, op_d;
  logic [DW-1:0] ac_q, ac_d, alu;
  logic [3:0] ir_q, ir_d;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      ac_q <= '0;
      ir_q <= '0;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      op_q <= op_d;
    end
  end
  assign alu = ir_q == OP_LDA ? MEM_RDATA :
               ir_q == OP_ADD ? ac_q + MEM_RDATA :
               ir_q == OP_SUB ? ac_q - MEM_RDATA :
               ir_q == OP_AND ? ac_q & MEM_RDATA : ac_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ac_d = ac_q;
    ir_d = ir_q;
    op_d = op_q;
    case (state_q)
      S_FETCH: if (MEM_ACK) begin
        ir_d = MEM_RDATA[DW-1 -: 4];
        op_d = MEM_RDATA[AW-1:0];
        pc_d = pc_q + AW'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (ir_q == OP_JMP || (ir_q == OP_BAN && AN) || (ir_q == OP_BAZ && AZ)) pc_d = op_q;
        state_d = ir_q == OP_HLT ? S_HALT : ir_q <= OP_AND ? S_EXEC : S_FETCH;
      end
      S_EXEC: if (MEM_ACK) begin
        ac_d = alu;
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end
  // Reset gates the strobes so a pending access is dropped the instant reset asserts.
  assign MEM_REQ   = RESET && (state_q == S_FETCH || state_q == S_EXEC);
  assign MEM_WE    = RESET && state_q == S_EXEC && ir_q == OP_STA;
  assign MEM_ADDR  = state_q == S_EXEC ? op_q : pc_q;
  assign MEM_WDATA = ac_q;
  assign PC_OUT    = pc_q;
  assign AC_OUT    = ac_q;
  assign IR_OUT    = ir_q;
  assign AZ        = ac_q == '0;
  assign AN        = ac_q[DW-1];
  assign FETCH     = state_q == S_FETCH;
  assign HALTED    = state_q == S_HALT;
endmodule

// File: tb/tb_dunc_core.sv
// tb_dunc_core: randomized and directed programs checked against an instruction-level model.
module tb_dunc_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req, we, ack, az, an, fetch, halted;
  logic [11:0] addr, pc;
  logic [15:0] wdata, rdata, ac;
  logic [3:0] ir;
  logic r2, req2, we2, az2, an2, f2, h2;
  logic ack2 = 1'b1;
  logic [15:0] addr2, pc2;
  logic [23:0] wd2, ac2;
  logic [23:0] rd2 = 24'hE00000;
  logic [3:0] ir2;
  int checks = 0, errors = 0;
  logic [15:0] mem [4096];
  int waits = 0, cnt = 0, run_len = 0, stab_err = 0, len_err = 0;
  logic [11:0] prev_addr;
  logic [3:0] opts [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

  dunc_core dut (.CLK(clk), .RESET(rst_n), .MEM_REQ(req), .MEM_WE(we), .MEM_ADDR(addr),
    .MEM_WDATA(wdata), .MEM_RDATA(rdata), .MEM_ACK(ack), .PC_OUT(pc), .AC_OUT(ac),
    .IR_OUT(ir), .AZ(az), .AN(an), .FETCH(fetch), .HALTED(halted));
  dunc_core #(.DW(24), .AW(16), .RESET_PC(16'hFFFF)) dut2 (.CLK(clk), .RESET(r2),
    .MEM_REQ(req2), .MEM_WE(we2), .MEM_ADDR(addr2), .MEM_WDATA(wd2), .MEM_RDATA(rd2),
    .MEM_ACK(ack2), .PC_OUT(pc2), .AC_OUT(ac2), .IR_OUT(ir2), .AZ(az2), .AN(an2),
    .FETCH(f2), .HALTED(h2));

  always @(negedge clk) begin
    if (req) begin
      ack = (cnt == waits);
      rdata = mem[addr];
      cnt = ack ? 0 : cnt + 1;
    end else begin
      ack = 1'b0;
      cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (req) begin
      if (run_len > 0 && addr !== prev_addr) stab_err++;
      prev_addr = addr;
      run_len++;
      if (ack) begin
        if (we) mem[addr] = wdata;
        if (run_len != waits + 1) len_err++;
        run_len = 0;
      end
    end else run_len = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] o, input logic [11:0] a);
    return {o, a};
  endfunction

  task automatic run_prog(input int w, input string tag, output logic [11:0] mpc,
                          output logic [15:0] mac, output int n);
    logic [15:0] mm [4096];
    logic [15:0] iw;
    logic [11:0] op;
    int mcyc, diffs;
    mm = mem;
    mpc = '0;
    mac = '0;
    mcyc = 0;
    for (int s = 0; s < 1000; s++) begin
      iw = mm[mpc];
      op = iw[11:0];
      mpc = mpc + 12'd1;
      mcyc += w + 2;
      if (iw[15:12] <= 4'h4) mcyc += w + 1;
      case (iw[15:12])
        4'h0: mac = mm[op];
        4'h1: mm[op] = mac;
        4'h2: mac = mac + mm[op];
        4'h3: mac = mac - mm[op];
        4'h4: mac = mac & mm[op];
        4'h5: mpc = op;
        4'h6: if (mac[15]) mpc = op;
        4'h7: if (mac == 16'h0) mpc = op;
        4'hF: break;
        default: ;
      endcase
    end
    waits = w;
    stab_err = 0;
    len_err = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1 n++;
      if (halted) break;
    end
    chk({tag, ".cycles"}, n, mcyc);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".pc"}, pc, mpc);
    chk({tag, ".ac"}, ac, mac);
    chk({tag, ".az"}, az, mac == 16'h0);
    chk({tag, ".an"}, an, mac[15]);
    chk({tag, ".req_idle"}, req, 1'b0);
    chk({tag, ".addr_stable"}, stab_err, 0);
    chk({tag, ".req_len"}, len_err, 0);
    diffs = 0;
    for (int k = 0; k < 4096; k++) if (mem[k] !== mm[k]) diffs++;
    chk({tag, ".mem"}, diffs, 0);
  endtask

  initial begin
    logic [11:0] mpc;
    logic [15:0] mac;
    int n, len;
    logic [3:0] o;
    rst_n = 1'b0;
    r2 = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    mem[0] = ins(4'hF, 12'h0);
    waits = 100;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stall.req", req, 1'b1);
    chk("stall.addr", addr, 12'h000);
    chk("stall.fetch", fetch, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.req", req, 1'b0);
    chk("rst.we", we, 1'b0);
    chk("rst.pc", pc, 12'h000);
    chk("rst.ac", ac, 16'h0000);
    chk("rst.az", az, 1'b1);
    chk("rst.an", an, 1'b0);
    chk("rst.ir", ir, 4'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rel.req", req, 1'b1);
    chk("rel.addr", addr, 12'h000);

    foreach (mem[i]) mem[i] = '0;
    mem[0] = ins(4'h0, 12'h010);
    mem[1] = ins(4'h2, 12'h011);
    mem[2] = ins(4'h1, 12'h012);
    mem[3] = ins(4'hF, 12'h000);
    mem[12'h010] = 16'h7FFF;
    mem[12'h011] = 16'h0001;
    run_prog(0, "p0", mpc, mac, n);
    chk("p0.n11", n, 11);
    chk("p0.store", mem[12'h012], 16'h8000);
    chk("p0.pc4", pc, 12'h004);
    chk("p0.an1", an, 1'b1);
    mem[12'h012] = '0;
    run_prog(3, "p3", mpc, mac, n);
    chk("p3.n32", n, 32);
    chk("p3.store", mem[12'h012], 16'h8000);
    chk("p3.pc4", pc, 12'h004);

    foreach (mem[i]) mem[i] = '0;
    mem[0] = ins(4'h0, 12'h030);
    mem[1] = ins(4'h7, 12'h020);
    mem[2] = ins(4'hF, 12'h000);
    mem[12'h020] = ins(4'hF, 12'h000);
    run_prog(0, "baz_t", mpc, mac, n);
    chk("baz_t.pc", pc, 12'h021);
    mem[12'h030] = 16'h0005;
    run_prog(1, "baz_n", mpc, mac, n);
    chk("baz_n.pc", pc, 12'h003);

    foreach (mem[i]) mem[i] = '0;
    mem[0] = ins(4'h0, 12'h030);
    mem[1] = ins(4'h3, 12'h031);
    mem[2] = ins(4'hF, 12'h000);
    mem[12'h031] = 16'h0001;
    run_prog(0, "sub", mpc, mac, n);
    chk("sub.ac", ac, 16'hFFFF);
    chk("sub.an", an, 1'b1);
    chk("sub.az", az, 1'b0);

    for (int r = 0; r < 20; r++) begin
      foreach (mem[i]) mem[i] = '0;
      len = $urandom_range(4, 14);
      for (int i = 0; i < len - 1; i++) begin
        o = opts[$urandom_range(0, 8)];
        if (o >= 4'h5 && o <= 4'h7 && i < len - 2) mem[i] = ins(o, 12'(i + 2));
        else if (o >= 4'h5 && o <= 4'h7) mem[i] = ins(4'h8, 12'h0);
        else mem[i] = ins(o, 12'h100 + 12'($urandom_range(0, 15)));
      end
      mem[len - 1] = ins(4'hF, 12'h000);
      for (int k = 0; k < 16; k++)
        mem[12'h100 + k] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_prog($urandom_range(0, 3), $sformatf("rnd%0d", r), mpc, mac, n);
    end

    @(posedge clk);
    #2 r2 = 1'b1;
    #1;
    chk("wrap.addr0", addr2, 16'hFFFF);
    chk("wrap.req", req2, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap.pc", pc2, 16'h0000);
    chk("wrap.decode", f2, 1'b0);
    @(posedge clk);
    #1;
    chk("wrap.addr1", addr2, 16'h0000);
    chk("wrap.fetch", f2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
